// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e     : converter FSM states (IDLE, SHIFT, DONE)
//   SEG_BLANK   : active-low 7-seg pattern with every segment off
//   seg7_of()   : BCD digit -> active-low {g,f,e,d,c,b,a} pattern
//   min_digits(): decimal digits needed to hold 2**bin_w-1
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;  // A-F never produced by a valid conversion
        endcase
        return s;
    endfunction

    function automatic int min_digits(input int bin_w);
        longint unsigned v;
        int              n;
        v = (64'd1 << bin_w) - 64'd1;
        n = 0;
        do begin
            n = n + 1;
            v = v / 64'd10;
        end while (v != 64'd0);
        return n;
    endfunction

endpackage

// File: rtl/bcd_seg7_dec.sv
// Per-digit 7-segment decoder (combinational).
//   digit_i : BCD digit
//   blank_i : 1 forces all segments off
//   seg_o   : active-low {g,f,e,d,c,b,a}
module bcd_seg7_dec
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : seg7_of(digit_i);

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Multi-cycle binary-to-BCD converter, double-dabble one bit per clock,
// with registered 7-seg patterns and optional leading-zero blanking.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   i_valid/i_ready     : input handshake, i_bin = unsigned binary word
//   o_valid/o_ready     : output handshake
//   o_bcd               : packed BCD, digit k at [4k+3:4k], k=0 is ones
//   o_seg               : active-low gfedcba per digit, digit k at [7k+6:7k]
//   o_digit_en          : 1 = digit k is significant
// Result outputs hold the last conversion until the next one completes.
module seq_bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int BIN_W    = 16,
    parameter int DIGITS   = 5,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [7*DIGITS-1:0]   o_seg,
    output logic [DIGITS-1:0]     o_digit_en
);

    localparam int CNT_W = $clog2(BIN_W);

    generate
        if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
            $error("seq_bin_to_bcd: BIN_W out of range 4..32");
        end
        if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
            $error("seq_bin_to_bcd: DIGITS too small for BIN_W");
        end
    endgenerate

    state_e               state_q;
    logic [BIN_W-1:0]     bin_q,  bin_d;
    logic [4*DIGITS-1:0]  bcd_q,  bcd_d;
    logic [4*DIGITS-1:0]  bcd_adj;
    logic [CNT_W-1:0]     cnt_q;
    logic                 fin_q;
    logic                 i_ready_q, o_valid_q;
    logic [4*DIGITS-1:0]  o_bcd_q;
    logic [7*DIGITS-1:0]  o_seg_q;
    logic [DIGITS-1:0]    o_en_q;

    // Double-dabble step: add 3 to each digit >= 5, then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    assign {bcd_d, bin_d} = {bcd_adj[4*DIGITS-2:0], bin_q, 1'b0};

    // Digit k is significant if it or any higher digit is nonzero; ones
    // digit is always significant.
    logic [DIGITS-1:0] en_c;
    logic              any_hi;
    always_comb begin
        en_c   = '0;
        any_hi = 1'b0;
        for (int k = DIGITS-1; k >= 0; k--) begin
            any_hi  = any_hi | (|bcd_q[4*k +: 4]);
            en_c[k] = any_hi;
        end
        en_c[0] = 1'b1;
    end

    logic [7*DIGITS-1:0] seg_c;
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_dec
            bcd_seg7_dec u_dec (
                .digit_i (bcd_q[4*g +: 4]),
                .blank_i (LZ_BLANK && !en_c[g]),
                .seg_o   (seg_c[7*g +: 7])
            );
        end
    endgenerate

    // SHIFT runs BIN_W shift cycles, then one more (fin_q) to capture the
    // settled accumulator into the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
            o_bcd_q   <= '0;
            o_seg_q   <= {DIGITS{SEG_BLANK}};
            o_en_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        bin_q     <= i_bin;
                        bcd_q     <= '0;
                        cnt_q     <= CNT_W'(BIN_W-1);
                        fin_q     <= 1'b0;
                        i_ready_q <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fin_q) begin
                        o_bcd_q   <= bcd_q;
                        o_seg_q   <= seg_c;
                        o_en_q    <= en_c;
                        o_valid_q <= 1'b1;
                        fin_q     <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        bcd_q <= bcd_d;
                        bin_q <= bin_d;
                        if (cnt_q == '0)
                            fin_q <= 1'b1;
                        else
                            cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid_q <= 1'b0;
                        i_ready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_ready    = i_ready_q;
    assign o_valid    = o_valid_q;
    assign o_bcd      = o_bcd_q;
    assign o_seg      = o_seg_q;
    assign o_digit_en = o_en_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
module tb_seq_bin_to_bcd;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit converters (blanked and unblanked) driven in lockstep
    logic        iv16 = 1'b0, or16 = 1'b0;
    logic [15:0] bin16 = '0;
    logic        ir16, ov16, irnb, ovnb;
    logic [19:0] bcd16, bcdnb;
    logic [34:0] seg16, segnb;
    logic [4:0]  en16, ennb;

    // 7-bit converter
    logic        iv7 = 1'b0, or7 = 1'b0;
    logic [6:0]  bin7 = '0;
    logic        ir7, ov7;
    logic [11:0] bcd7;
    logic [20:0] seg7;
    logic [2:0]  en7;

    int n_vec = 0;
    int n_err = 0;

    seq_bin_to_bcd #(.BIN_W(16), .DIGITS(5), .LZ_BLANK(1'b1)) u16 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv16), .i_ready(ir16), .i_bin(bin16),
        .o_valid(ov16), .o_ready(or16), .o_bcd(bcd16), .o_seg(seg16), .o_digit_en(en16));

    seq_bin_to_bcd #(.BIN_W(16), .DIGITS(5), .LZ_BLANK(1'b0)) unb (
        .clk(clk), .rst_n(rst_n), .i_valid(iv16), .i_ready(irnb), .i_bin(bin16),
        .o_valid(ovnb), .o_ready(or16), .o_bcd(bcdnb), .o_seg(segnb), .o_digit_en(ennb));

    seq_bin_to_bcd #(.BIN_W(7), .DIGITS(3), .LZ_BLANK(1'b1)) u7 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv7), .i_ready(ir7), .i_bin(bin7),
        .o_valid(ov7), .o_ready(or7), .o_bcd(bcd7), .o_seg(seg7), .o_digit_en(en7));

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic longint unsigned pow10(input int k);
        longint unsigned p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] ref_seg(input longint unsigned d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int nd);
        logic [63:0] r = '0;
        for (int k = 0; k < nd; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [63:0] ref_en(input longint unsigned v, input int nd);
        logic [63:0] r = '0;
        for (int k = 0; k < nd; k++) r[k] = (k == 0) || (v >= pow10(k));
        return r;
    endfunction

    function automatic logic [63:0] ref_segs(input longint unsigned v, input int nd, input bit lz);
        logic [63:0] r = '0;
        logic [63:0] en = ref_en(v, nd);
        for (int k = 0; k < nd; k++)
            r[7*k +: 7] = (lz && !en[k]) ? 7'h7F : ref_seg((v / pow10(k)) % 10);
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic [15:0] v);
        int n = 0;
        bin16 = v;
        iv16  = 1'b1;
        while (!(ir16 && irnb) && n < 50) begin cyc(); n++; end
        chk("send16_timeout", 64'(n < 50), 64'd1);
        cyc();                          // accept edge
        iv16 = 1'b0;
        chk("send16_busy", {62'd0, ir16, irnb}, 64'd0);
    endtask

    task automatic wait16(input logic [15:0] v);
        int n = 0;
        do begin cyc(); n++; end while (!ov16 && n < 40);
        chk("lat16", 64'(n), 64'd17);
        chk("valnb", 64'(ovnb), 64'd1);
        chk("bcd16", 64'(bcd16), ref_bcd(v, 5));
        chk("seg16", 64'(seg16), ref_segs(v, 5, 1'b1));
        chk("en16",  64'(en16),  ref_en(v, 5));
        chk("bcdnb", 64'(bcdnb), ref_bcd(v, 5));
        chk("segnb", 64'(segnb), ref_segs(v, 5, 1'b0));
        chk("ennb",  64'(ennb),  ref_en(v, 5));
    endtask

    task automatic take16(input logic [15:0] v);
        or16 = 1'b1;
        cyc();
        or16 = 1'b0;
        chk("take16_vld", {62'd0, ov16, ovnb}, 64'd0);
        chk("take16_rdy", {62'd0, ir16, irnb}, 64'd3);
        chk("hold16", 64'(bcd16), ref_bcd(v, 5));
    endtask

    task automatic conv7(input logic [6:0] v);
        int n = 0;
        bin7 = v;
        iv7  = 1'b1;
        while (!ir7 && n < 50) begin cyc(); n++; end
        chk("send7_timeout", 64'(n < 50), 64'd1);
        cyc();
        iv7 = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (!ov7 && n < 30);
        chk("lat7",  64'(n), 64'd8);
        chk("bcd7",  64'(bcd7), ref_bcd(v, 3));
        chk("seg7",  64'(seg7), ref_segs(v, 3, 1'b1));
        chk("en7",   64'(en7),  ref_en(v, 3));
        or7 = 1'b1;
        cyc();
        or7 = 1'b0;
        chk("take7_vld", 64'(ov7), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] a, b;
        #12;
        // reset state
        chk("rst_rdy", {61'd0, ir16, irnb, ir7}, 64'd7);
        chk("rst_vld", {61'd0, ov16, ovnb, ov7}, 64'd0);
        chk("rst_bcd", 64'(bcd16), 64'd0);
        chk("rst_seg", 64'(seg16), 64'h7_FFFF_FFFF);
        chk("rst_en",  64'(en16),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // zero: only ones digit lit
        send16(16'd0); wait16(16'd0);
        chk("zero_seg", 64'(seg16), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
        chk("zero_en",  64'(en16),  64'd1);
        take16(16'd0);

        // max value
        send16(16'hFFFF); wait16(16'hFFFF);
        chk("max_bcd",  64'(bcd16), 64'h65535);
        chk("max_seg4", 64'(seg16[34:28]), 64'h02);
        chk("max_en",   64'(en16), 64'h1F);
        take16(16'hFFFF);

        // 305: blanked vs unblanked
        send16(16'd305); wait16(16'd305);
        chk("305_segnb", 64'(segnb), 64'({7'h40, 7'h40, 7'h30, 7'h40, 7'h12}));
        chk("305_seg16", 64'(seg16), 64'({7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12}));
        chk("305_ennb",  64'(ennb),  64'b00111);
        take16(16'd305);

        // random words
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom_range(0, 65535));
            send16(a); wait16(a); take16(a);
        end

        // back-pressure with a new word waiting upstream
        a = 16'd4321;
        b = 16'($urandom_range(0, 65535));
        send16(a); wait16(a);
        bin16 = b;
        iv16  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("bp_vld", 64'(ov16), 64'd1);
            chk("bp_bcd", 64'(bcd16), ref_bcd(a, 5));
            chk("bp_rdy", 64'(ir16), 64'd0);
        end
        or16 = 1'b1;
        cyc();
        or16 = 1'b0;
        chk("bp_hs_vld", 64'(ov16), 64'd0);
        chk("bp_hs_rdy", 64'(ir16), 64'd1);
        send16(b);                      // accepted on the very next edge
        wait16(b); take16(b);

        // reset during SHIFT cycle 5
        send16(16'd12345);
        repeat (4) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(ov16), 64'd0);
        chk("mid_rst_bcd", 64'(bcd16), 64'd0);
        chk("mid_rst_seg", 64'(seg16), 64'h7_FFFF_FFFF);
        chk("mid_rst_rdy", 64'(ir16), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        send16(16'd9); wait16(16'd9);
        chk("post_rst_bcd", 64'(bcd16), 64'h00009);
        take16(16'd9);

        // 7-bit sweep
        for (int v = 0; v < 128; v++) conv7(7'(v));
        chk("bcd7_127", 64'(bcd7), 64'h127);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
